// File: rtl/ddr_packet_reader.sv
// Fetches one descriptor + payload packet from the 256-bit DDR read port and
// serialises the payload as 32-bit valid/ready words with sop/eop/empty framing.
//
// state     | meaning
// IDLE      | waiting for start
// RD_DESC   | descriptor read request pending
// WAIT_DESC | waiting for descriptor line (timeout armed)
// CHECK     | validate length, derive word count and eop empty bytes
// RD_LINE   | payload read request pending (raised one cycle after entry)
// WAIT_LINE | waiting for payload line (timeout armed)
// STREAM    | presenting holding-register lanes; done is raised on eop accept
module ddr_packet_reader #(
    parameter logic [24:0] BASE_ADDR  = 25'd1,
    parameter int          MAX_LEN    = 1024,
    parameter int          RD_TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         mem_rd_rq,
    input  logic         mem_rd_ready,
    output logic [24:0]  mem_rd_addr,
    input  logic         mem_rd_valid,
    input  logic [255:0] mem_rd_data,
    output logic [31:0]  tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_sop,
    output logic         tx_eop,
    output logic [1:0]   tx_empty
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_DESC,
        ST_WAIT_DESC,
        ST_CHECK,
        ST_RD_LINE,
        ST_WAIT_LINE,
        ST_STREAM
    } state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(RD_TIMEOUT - 1);

    state_t         state;
    logic [15:0]    len;
    logic [8:0]     words;
    logic [1:0]     empty_last;
    logic [24:0]    line;
    logic [2:0]     lane;
    logic [255:0]   holding;
    logic [15:0]    tmo_cnt;
    logic           first_word;

    logic [2:0]     lane_nxt;
    logic [31:0]    lane_word;
    logic [31:0]    next_word;

    assign lane_nxt  = lane + 3'd1;
    assign lane_word = holding[{lane, 5'b0} +: 32];
    assign next_word = holding[{lane_nxt, 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_rq   <= 1'b0;
            mem_rd_addr <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_sop      <= 1'b0;
            tx_eop      <= 1'b0;
            tx_empty    <= '0;
            len         <= '0;
            words       <= '0;
            empty_last  <= '0;
            line        <= '0;
            lane        <= '0;
            holding     <= '0;
            tmo_cnt     <= '0;
            first_word  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        mem_rd_rq   <= 1'b1;
                        mem_rd_addr <= BASE_ADDR;
                        state       <= ST_RD_DESC;
                    end
                end
                ST_RD_DESC: begin
                    if (mem_rd_ready) begin
                        mem_rd_rq <= 1'b0;
                        tmo_cnt   <= 16'd1;
                        state     <= ST_WAIT_DESC;
                    end
                end
                ST_WAIT_DESC: begin
                    if (mem_rd_valid) begin
                        len     <= mem_rd_data[15:0];
                        tmo_cnt <= '0;
                        state   <= ST_CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (len == 16'd0 || len > MAX_LEN_W) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        words      <= 9'((len + 16'd3) >> 2);
                        empty_last <= 2'd0 - len[1:0];
                        line       <= BASE_ADDR + 25'd1;
                        first_word <= 1'b1;
                        state      <= ST_RD_LINE;
                    end
                end
                ST_RD_LINE: begin
                    if (!mem_rd_rq) begin
                        mem_rd_rq   <= 1'b1;
                        mem_rd_addr <= line;
                    end else if (mem_rd_ready) begin
                        mem_rd_rq <= 1'b0;
                        tmo_cnt   <= 16'd1;
                        state     <= ST_WAIT_LINE;
                    end
                end
                ST_WAIT_LINE: begin
                    if (mem_rd_valid) begin
                        holding <= mem_rd_data;
                        lane    <= '0;
                        tmo_cnt <= '0;
                        state   <= ST_STREAM;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_STREAM: begin
                    // First cycle in STREAM loads the current lane; later words load on accept.
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= lane_word;
                        tx_sop   <= first_word;
                        tx_eop   <= (words == 9'd1);
                        tx_empty <= (words == 9'd1) ? empty_last : 2'd0;
                    end else if (tx_ready) begin
                        words      <= words - 9'd1;
                        lane       <= lane_nxt;
                        first_word <= 1'b0;
                        if (words == 9'd1) begin
                            tx_valid <= 1'b0;
                            tx_sop   <= 1'b0;
                            tx_eop   <= 1'b0;
                            tx_empty <= 2'd0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else if (lane == 3'd7) begin
                            tx_valid <= 1'b0;
                            tx_sop   <= 1'b0;
                            tx_eop   <= 1'b0;
                            tx_empty <= 2'd0;
                            line     <= line + 25'd1;
                            state    <= ST_RD_LINE;
                        end else begin
                            tx_data  <= next_word;
                            tx_sop   <= 1'b0;
                            tx_eop   <= (words == 9'd2);
                            tx_empty <= (words == 9'd2) ? empty_last : 2'd0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_packet_reader.sv
// Randomised bench for ddr_packet_reader: a DDR line responder plus a packet
// model built from length arithmetic, compared against every accepted word.
module tb_ddr_packet_reader;

    localparam int          RD_TIMEOUT = 1000;
    localparam int          MAX_LEN    = 1024;
    localparam logic [24:0] BASE       = 25'd1;

    typedef logic [35:0] word_t;  // {sop, eop, empty[1:0], data}

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, err, mem_rd_rq;
    logic         mem_rd_ready = 1'b0;
    logic [24:0]  mem_rd_addr;
    logic         mem_rd_valid = 1'b0;
    logic [255:0] mem_rd_data = '0;
    logic [31:0]  tx_data;
    logic         tx_valid, tx_sop, tx_eop;
    logic         tx_ready = 1'b0;
    logic [1:0]   tx_empty;

    ddr_packet_reader #(.BASE_ADDR(BASE), .MAX_LEN(MAX_LEN), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .mem_rd_rq(mem_rd_rq), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [255:0] mem_lines [0:63];
    word_t        exp_q[$];
    word_t        got_w[$];
    logic [24:0]  exp_rd[$];
    logic [24:0]  got_rd[$];
    word_t        t1_w[16];

    int n_pass = 0, n_total = 0;
    int pkt_len = 0, pkt_seq = 0, seen_seq = 0;
    int tx_mode = 0, mem_mode = 0, mem_delay = 1, supp_addr = -1;
    int late_req = 0, late_done = 0;
    int pend_cnt = -1, pat_idx = 0;
    logic [24:0] pend_addr = '0;
    logic  prev_stall = 1'b0;
    word_t prev_word = '0;
    int err_cnt = 0, done_cnt = 0;
    int last_err_cyc = 0, last_acc_cyc = 0, last_eop_cyc = 0;
    int st_cyc = 0, rq_lat = -1, tv_lat = -1;
    logic busy1 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Packet model: word i lives in lane i%8 of line BASE+1+i/8.
    task automatic build_model();
        int nw, ln, emp;
        exp_q.delete();
        exp_rd.delete();
        got_w.delete();
        got_rd.delete();
        exp_rd.push_back(BASE);
        if (pkt_len != 0 && pkt_len <= MAX_LEN) begin
            nw = (pkt_len + 3) / 4;
            for (int i = 0; i < nw; i++) begin
                ln = int'(BASE) + 1 + i / 8;
                if (i % 8 == 0) exp_rd.push_back(25'(ln));
                emp = (i == nw - 1) ? (4 - pkt_len % 4) % 4 : 0;
                exp_q.push_back({(i == 0), (i == nw - 1), 2'(emp), mem_lines[ln][32*(i%8) +: 32]});
            end
        end
    endtask

    task automatic monitor();
        word_t cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_cnt     = -1;
                prev_stall   = 1'b0;
                exp_q.delete();
                exp_rd.delete();
                mem_rd_valid = 1'b0;
                mem_rd_data  = '0;
                mem_rd_ready = 1'b0;
                tx_ready     = 1'b0;
            end else begin
                if (pkt_seq != seen_seq) begin
                    seen_seq = pkt_seq;
                    build_model();
                end
                if (err) begin
                    err_cnt++;
                    last_err_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_eop", 64'(cyc - last_eop_cyc), 64'd1);
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                end
                mem_rd_valid = 1'b0;
                mem_rd_data  = '0;
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data  = mem_lines[pend_addr[5:0]];
                        pend_cnt     = -1;
                    end
                end
                if (late_req != late_done) begin
                    late_done    = late_req;
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_lines[2];
                end
                mem_rd_ready = (mem_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                case (tx_mode)
                    0: tx_ready = 1'b1;
                    1: begin
                        tx_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                        pat_idx++;
                    end
                    default: tx_ready = 1'($urandom_range(0, 1));
                endcase
                if (mem_rd_rq && mem_rd_ready) begin
                    got_rd.push_back(mem_rd_addr);
                    last_acc_cyc = cyc;
                    if (exp_rd.size() == 0) begin
                        n_total++;
                        $display("FAIL rd_addr: unexpected read of 0x%0h", mem_rd_addr);
                    end else begin
                        chk("rd_addr", 64'(mem_rd_addr), 64'(exp_rd.pop_front()));
                    end
                    if (int'(mem_rd_addr) != supp_addr) begin
                        pend_cnt  = mem_delay;
                        pend_addr = mem_rd_addr;
                    end
                end
                cur = {tx_sop, tx_eop, tx_empty, tx_data};
                if (tx_valid) begin
                    if (prev_stall) chk("tx_hold", 64'(cur), 64'(prev_word));
                    if (tx_ready) begin
                        got_w.push_back(cur);
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL tx_word: unexpected word 0x%0h", cur);
                        end else begin
                            chk("tx_word", 64'(cur), 64'(exp_q.pop_front()));
                        end
                        if (tx_eop) last_eop_cyc = cyc;
                        prev_stall = 1'b0;
                    end else begin
                        prev_stall = 1'b1;
                        prev_word  = cur;
                    end
                end else begin
                    if (prev_stall) begin
                        n_total++;
                        $display("FAIL tx_hold: tx_valid dropped during stall, got 0 expected 1");
                    end
                    prev_stall = 1'b0;
                end
            end
        end
    endtask

    task automatic launch(input int len, input int dly, input int txm, input int memm, input int supp);
        for (int k = 1; k < 8; k++) mem_lines[1][32*k +: 32] = $urandom();
        mem_lines[1][31:16] = 16'($urandom());
        mem_lines[1][15:0]  = 16'(len);
        pkt_len   = len;
        mem_delay = dly;
        tx_mode   = txm;
        mem_mode  = memm;
        supp_addr = supp;
        pkt_seq++;
        tick();
        start  = 1'b1;
        st_cyc = cyc;
    endtask

    // res: 1 = done, 2 = err, 0 = neither within budget
    task automatic wait_end(input int budget, output int res);
        int e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        res = 0;
        rq_lat = -1;
        tv_lat = -1;
        for (int i = 0; i < budget && res == 0; i++) begin
            tick();
            start = 1'b0;
            if (i == 0) busy1 = busy;
            if (mem_rd_rq && rq_lat < 0) rq_lat = cyc - st_cyc;
            if (tx_valid && tv_lat < 0) tv_lat = cyc - st_cyc;
            if (done_cnt != d0) res = 1;
            else if (err_cnt != e0) res = 2;
        end
        if (res == 0) begin
            n_total++;
            $display("FAIL wait_end: no done/err within %0d cycles", budget);
        end
    endtask

    initial begin
        int res, e0, d0, len, nd;
        for (int l = 0; l < 64; l++)
            for (int k = 0; k < 8; k++) mem_lines[l][32*k +: 32] = $urandom();
        mem_lines[2][31:0]  = 32'h000014CC;
        mem_lines[2][63:32] = 32'h2005BF6B;
        fork
            monitor();
        join_none

        repeat (3) tick();
        chk("reset_ctrl", 64'({busy, done, err, mem_rd_rq, tx_valid, tx_sop, tx_eop, tx_empty}), 64'd0);
        chk("reset_data", 64'({mem_rd_addr, tx_data}), 64'd0);
        rst_n = 1'b1;
        tick();

        // 64-byte packet, free-running sink, memory latency 3
        launch(64, 3, 0, 0, -1);
        wait_end(300, res);
        chk("t1_done", 64'(res), 64'd1);
        chk("t1_busy_after_start", {63'd0, busy1}, 64'd1);
        chk("t1_rq_latency", 64'(rq_lat), 64'd1);
        chk("t1_tv_latency", 64'(tv_lat), 64'(2 * 3 + 6));
        chk("t1_nwords", 64'(got_w.size()), 64'd16);
        chk("t1_word0", 64'(got_w[0]), 64'h8_0000_14CC);
        chk("t1_word1", 64'(got_w[1]), 64'h0_2005_BF6B);
        chk("t1_word15_flags", 64'(got_w[15][35:32]), 64'b0100);
        chk("t1_reads", 64'({got_rd.size(), got_rd[0], got_rd[1], got_rd[2]}) ,
            64'({32'd3, 25'd1, 25'd2, 25'd3}));
        chk("t1_model_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 16; i++) t1_w[i] = got_w[i];

        // 46 bytes: 12 words, eop in lane 3 of line 3 with two empty bytes
        launch(46, 2, 0, 0, -1);
        wait_end(300, res);
        chk("t2_done", 64'(res), 64'd1);
        chk("t2_nwords", 64'(got_w.size()), 64'd12);
        chk("t2_word11_flags", 64'(got_w[11][35:32]), 64'b0110);
        chk("t2_reads", 64'(got_rd.size()), 64'd3);

        // Same 64-byte packet with a 1,0,0,1 ready pattern
        launch(64, 4, 1, 0, -1);
        wait_end(400, res);
        chk("t3_done", 64'(res), 64'd1);
        chk("t3_nwords", 64'(got_w.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk("t3_same_as_t1", 64'(got_w[i]), 64'(t1_w[i]));

        // Illegal lengths, then a single-word packet
        launch(0, 2, 0, 0, -1);
        wait_end(100, res);
        chk("t4_len0_err", 64'(res), 64'd2);
        chk("t4_len0_no_tx", {63'd0, tv_lat < 0}, 64'd1);
        chk("t4_len0_idle", {63'd0, busy}, 64'd0);
        launch(1025, 2, 0, 0, -1);
        wait_end(100, res);
        chk("t4_len1025_err", 64'(res), 64'd2);
        chk("t4_len1025_no_tx", {63'd0, tv_lat < 0}, 64'd1);
        launch(4, 2, 0, 0, -1);
        wait_end(100, res);
        chk("t4_len4_done", 64'(res), 64'd1);
        chk("t4_len4_nwords", 64'(got_w.size()), 64'd1);
        chk("t4_len4_flags", 64'(got_w[0][35:32]), 64'b1100);

        // Line-2 read never returns: timeout, then a late return is ignored
        launch(64, 2, 0, 0, 2);
        wait_end(RD_TIMEOUT + 200, res);
        chk("t5_timeout_err", 64'(res), 64'd2);
        chk("t5_timeout_cycles", 64'(last_err_cyc - last_acc_cyc), 64'(RD_TIMEOUT));
        chk("t5_no_tx", {63'd0, tv_lat < 0}, 64'd1);
        e0 = err_cnt;
        late_req++;
        repeat (5) tick();
        chk("t5_late_ignored", 64'({busy, tx_valid, mem_rd_rq, err_cnt != e0}), 64'd0);
        launch(64, 2, 0, 0, -1);
        wait_end(300, res);
        chk("t5_recover_done", 64'(res), 64'd1);
        chk("t5_recover_nwords", 64'(got_w.size()), 64'd16);

        // Reset while word 5 is on the bus
        launch(64, 3, 0, 0, -1);
        nd = 0;
        for (int i = 0; i < 200 && got_w.size() < 4; i++) begin
            tick();
            start = 1'b0;
            nd = i;
        end
        chk("t6_reached_word5", 64'(got_w.size()), 64'd4);
        tick();
        e0 = err_cnt;
        d0 = done_cnt;
        rst_n = 1'b0;
        tick();
        chk("t6_reset_ctrl", 64'({busy, done, err, mem_rd_rq, tx_valid, tx_sop, tx_eop, tx_empty}), 64'd0);
        chk("t6_reset_data", 64'({mem_rd_addr, tx_data}), 64'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_no_pulses", 64'({err_cnt - e0, done_cnt - d0}), 64'd0);
        launch(64, 3, 0, 0, -1);
        wait_end(300, res);
        chk("t6_restart_done", 64'(res), 64'd1);
        chk("t6_restart_nwords", 64'(got_w.size()), 64'd16);
        chk("t6_restart_word0", 64'(got_w[0]), 64'h8_0000_14CC);

        // Random lengths, latencies and back-pressure on both sides
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 200);
            launch(len, $urandom_range(1, 6), 2, 1, -1);
            wait_end(2000, res);
            chk("rnd_done", 64'(res), 64'd1);
            chk("rnd_nwords", 64'(got_w.size()), 64'((len + 3) / 4));
            chk("rnd_reads_drained", 64'(exp_rd.size()), 64'd0);
        end
        if (nd < 0) $display("note: unreachable");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
